// File: rtl/seg_dynamic_scan.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// seg_dynamic_scan
// Eight-digit multiplexed seven-segment driver for a common-anode display.
// The eight BCD digits, the decimal-point mask and the blanking enable are
// snapshotted once per frame (as the scan wraps from digit 7 to digit 0), so a
// frame never mixes old and new digits. Leading zeros can be suppressed. Each
// digit slot starts with a dead time where every select is off to avoid
// ghosting. Select and segment lines are registered and drive the pins.
//
// Parameters
//   SCAN_DIV  clock cycles per digit slot (>= DEAD_CYC+2)
//   DEAD_CYC  all-off cycles at the start of every slot (>= 0)
// Ports
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   unit..t_mil in  4-bit digits, unit = digit 0 ... t_mil = digit 7
//   point      in   decimal-point enable, bit k = digit k
//   blank_en   in   1 = leading-zero suppression
//   sel        out  active-low one-hot digit select, bit k = digit k
//   seg        out  active-low segments {dp,g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module seg_dynamic_scan #(
    parameter int unsigned SCAN_DIV = 100_000,
    parameter int unsigned DEAD_CYC = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] unit,
    input  logic [3:0] ten,
    input  logic [3:0] hun,
    input  logic [3:0] tho,
    input  logic [3:0] t_tho,
    input  logic [3:0] h_hun,
    input  logic [3:0] mil,
    input  logic [3:0] t_mil,
    input  logic [7:0] point,
    input  logic       blank_en,
    output logic [7:0] sel,
    output logic [7:0] seg
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_V = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_V = CNT_W'(DEAD_CYC);

    // Seven-segment pattern {g..a}, active-low; non-BCD values show a minus.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h3F;
        endcase
        return p;
    endfunction

    logic [7:0][3:0] digits_s;
    logic [7:0][3:0] shadow_digit_r;
    logic [7:0]      shadow_point_r;
    logic            shadow_blank_en_r;
    logic [CNT_W-1:0] cnt_div_r;
    logic [2:0]      idx_r;
    logic            tick_s;
    logic            dead_s;
    logic [7:0]      blank_mask_s;
    logic            run_s;
    logic [7:0]      sel_nxt_s;
    logic [7:0]      seg_nxt_s;
    logic [7:0]      sel_r;
    logic [7:0]      seg_r;

    assign digits_s = {t_mil, mil, h_hun, t_tho, tho, hun, ten, unit};
    assign tick_s   = (cnt_div_r == TICK_V);
    assign dead_s   = (cnt_div_r < DEAD_V);

    // Slot divider and digit index; idx wraps 7->0 on the same tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_div_r <= '0;
            idx_r     <= 3'd0;
        end else if (tick_s) begin
            cnt_div_r <= '0;
            idx_r     <= idx_r + 3'd1;
        end else begin
            cnt_div_r <= cnt_div_r + CNT_W'(1);
        end
    end

    // Frame snapshot, loaded only as the scan leaves digit 7.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow_digit_r    <= '0;
            shadow_point_r    <= 8'h00;
            shadow_blank_en_r <= 1'b0;
        end else if (tick_s && (idx_r == 3'd7)) begin
            shadow_digit_r    <= digits_s;
            shadow_point_r    <= point;
            shadow_blank_en_r <= blank_en;
        end
    end

    // Leading-zero mask: walking down from digit 7, a digit stays blanked
    // while it and everything above it is a zero without a decimal point.
    always_comb begin
        blank_mask_s = 8'h00;
        run_s        = shadow_blank_en_r;
        for (int k = 7; k >= 1; k--) begin
            run_s = run_s && (shadow_digit_r[k] == 4'd0) && !shadow_point_r[k];
            blank_mask_s[k] = run_s;
        end
    end

    // Next select / segment values for the current slot position.
    always_comb begin
        sel_nxt_s = 8'hFF;
        seg_nxt_s = 8'hFF;
        if (dead_s) begin
            sel_nxt_s = 8'hFF;
            seg_nxt_s = 8'hFF;
        end else begin
            sel_nxt_s = ~(8'b0000_0001 << idx_r);
            if (blank_mask_s[idx_r]) begin
                seg_nxt_s = 8'hFF;
            end else begin
                seg_nxt_s = {~shadow_point_r[idx_r], seg_encode(shadow_digit_r[idx_r])};
            end
        end
    end

    // Registered pin drivers; reset forces every line off immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_r <= 8'hFF;
            seg_r <= 8'hFF;
        end else begin
            sel_r <= sel_nxt_s;
            seg_r <= seg_nxt_s;
        end
    end

    assign sel = sel_r;
    assign seg = seg_r;

endmodule
